// File: rtl/echo_request_fifo.sv
// Request-side FIFO of the Echo path: buffers say(v) calls in order and exposes first/deq to the responder.
// Optional request counter and req_total port are built only when ECHO_REQ_STATS_EN is defined.
module echo_request_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     say__ENA,
    input  logic [WIDTH-1:0]         say_v,
    output logic                     say__RDY,
    output logic                     first__RDY,
    output logic [WIDTH-1:0]         first,
    output logic                     deq__RDY,
    input  logic                     deq__ENA,
    output logic [$clog2(DEPTH):0]   count
`ifdef ECHO_REQ_STATS_EN
    ,
    output logic [31:0]              req_total
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             enq_c;
    logic             deq_c;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Handshakes qualified by registered flags only, so ENA never feeds back into RDY.
    always_comb begin
        enq_c    = say__ENA & ~full_q;
        deq_c    = deq__ENA & ~empty_q;
        wr_ptr_d = wr_ptr_q + PW'(enq_c);
        rd_ptr_d = rd_ptr_q + PW'(deq_c);
        count_d  = count_q + PW'(enq_c) - PW'(deq_c);
        empty_d  = (rd_ptr_d == wr_ptr_d);
        full_d   = (rd_ptr_d[AW-1:0] == wr_ptr_d[AW-1:0]) &&
                   (rd_ptr_d[AW] != wr_ptr_d[AW]);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Payload storage is deliberately left unreset; empty_q masks stale data.
    always_ff @(posedge CLK) begin
        if (enq_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= say_v;
        end
    end

    assign say__RDY   = ~full_q;
    assign first__RDY = ~empty_q;
    assign deq__RDY   = ~empty_q;
    assign count      = count_q;
    assign first      = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];

`ifdef ECHO_REQ_STATS_EN
    logic [31:0] req_total_q, req_total_d;

    always_comb begin
        req_total_d = req_total_q + 32'(enq_c);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_total_q <= '0;
        end else begin
            req_total_q <= req_total_d;
        end
    end

    assign req_total = req_total_q;
`endif

`ifndef SYNTHESIS
    // Protocol monitor; proto_chk_en lets a harness silence it around intentional misuse.
    bit proto_chk_en = 1'b1;

    always @(posedge CLK) begin
        if (nRST && proto_chk_en) begin
            assert (!(say__ENA && full_q))
                else $error("echo_request_fifo: say__ENA while say__RDY=0");
            assert (!(deq__ENA && empty_q))
                else $error("echo_request_fifo: deq__ENA while deq__RDY=0");
        end
    end
`endif

endmodule

// File: tb/tb_echo_request_fifo.sv
// Directed bench for echo_request_fifo: vector table plus hand-written reset, wrap and full-boundary sequences.
module tb_echo_request_fifo;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        say__ENA;
    logic [31:0] say_v;
    logic        say__RDY;
    logic        first__RDY;
    logic [31:0] first;
    logic        deq__RDY;
    logic        deq__ENA;
    logic [2:0]  count;
`ifdef ECHO_REQ_STATS_EN
    logic [31:0] req_total;
`endif

    echo_request_fifo #(.DEPTH(4), .WIDTH(32)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .say__ENA   (say__ENA),
        .say_v      (say_v),
        .say__RDY   (say__RDY),
        .first__RDY (first__RDY),
        .first      (first),
        .deq__RDY   (deq__RDY),
        .deq__ENA   (deq__ENA),
        .count      (count)
`ifdef ECHO_REQ_STATS_EN
        ,
        .req_total  (req_total)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        say;
        logic [31:0] v;
        logic        deq;
        logic        e_srdy;
        logic        e_frdy;
        logic [31:0] e_first;
        logic [2:0]  e_count;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vec [10];
    logic [31:0] model_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic srdy, input logic frdy,
                             input logic [31:0] f, input logic [2:0] c);
        chk({tag, ".say_rdy"},   32'(say__RDY),   32'(srdy));
        chk({tag, ".first_rdy"}, 32'(first__RDY), 32'(frdy));
        chk({tag, ".deq_rdy"},   32'(deq__RDY),   32'(frdy));
        chk({tag, ".first"},     first,           f);
        chk({tag, ".count"},     32'(count),      32'(c));
    endtask

    initial begin
        // Fill-to-full then drain; expectations are the outputs seen before each edge.
        vec[0] = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0, 3'd0};
        vec[1] = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 32'd1, 3'd1};
        vec[2] = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 32'd1, 3'd2};
        vec[3] = '{1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 32'd1, 3'd3};
        vec[4] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd1, 3'd4};
        vec[5] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd1, 3'd4};
        vec[6] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd2, 3'd3};
        vec[7] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd3, 3'd2};
        vec[8] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd4, 3'd1};
        vec[9] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 3'd0};

        nRST     = 1'b1;
        say__ENA = 1'b0;
        say_v    = '0;
        deq__ENA = 1'b0;

        // Reset before any clock edge
        #1 nRST = 1'b0;
        #1 chk_state("rst0", 1'b1, 1'b0, 32'd0, 3'd0);
`ifdef ECHO_REQ_STATS_EN
        chk("rst0.req_total", req_total, 32'd0);
`endif
        tick();
        tick();
        nRST = 1'b1;
        tick();

        // Single pass
        say__ENA = 1'b1; say_v = 32'h0000_002A;
        tick();
        say__ENA = 1'b0;
        chk_state("single.enq", 1'b1, 1'b1, 32'h2A, 3'd1);
        deq__ENA = 1'b1;
        tick();
        deq__ENA = 1'b0;
        chk_state("single.deq", 1'b1, 1'b0, 32'd0, 3'd0);

        // Vector table: fill and drain
        for (int i = 0; i < 10; i++) begin
            say__ENA = vec[i].say;
            say_v    = vec[i].v;
            deq__ENA = vec[i].deq;
            chk_state($sformatf("vec%0d", i), vec[i].e_srdy, vec[i].e_frdy,
                      vec[i].e_first, vec[i].e_count);
            if (i == 4) begin
                // Intentional enqueue while full must be ignored
                dut.proto_chk_en = 1'b0;
                say__ENA = 1'b1; say_v = 32'h99;
                tick();
                say__ENA = 1'b0;
                dut.proto_chk_en = 1'b1;
                chk_state("full.ignored", 1'b0, 1'b1, 32'd1, 3'd4);
            end else begin
                tick();
            end
        end
        say__ENA = 1'b0;
        deq__ENA = 1'b0;

        // Concurrent enq+deq at count=2 across pointer wrap
        model_q.delete();
        for (int i = 0; i < 2; i++) begin
            say__ENA = 1'b1; say_v = 32'h10 + 32'(i);
            model_q.push_back(say_v);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            say__ENA = 1'b1; deq__ENA = 1'b1; say_v = 32'h55 + 32'(i);
            chk($sformatf("conc%0d.first", i), first, model_q[0]);
            chk($sformatf("conc%0d.count", i), 32'(count), 32'd2);
            model_q.push_back(say_v);
            void'(model_q.pop_front());
            tick();
        end
        say__ENA = 1'b0;
        for (int i = 0; i < 2; i++) begin
            deq__ENA = 1'b1;
            chk($sformatf("concdrain%0d.first", i), first, model_q[0]);
            void'(model_q.pop_front());
            tick();
        end
        deq__ENA = 1'b0;
        chk_state("conc.end", 1'b1, 1'b0, 32'd0, 3'd0);

        // Full boundary: deq and say together while full, only the deq happens
        for (int i = 0; i < 4; i++) begin
            say__ENA = 1'b1; say_v = 32'hA0 + 32'(i);
            tick();
        end
        say__ENA = 1'b0;
        chk_state("bound.full", 1'b0, 1'b1, 32'hA0, 3'd4);
        dut.proto_chk_en = 1'b0;
        say__ENA = 1'b1; say_v = 32'hEE; deq__ENA = 1'b1;
        chk("bound.say_rdy_with_deq", 32'(say__RDY), 32'd0);
        tick();
        say__ENA = 1'b0; deq__ENA = 1'b0;
        dut.proto_chk_en = 1'b1;
        chk_state("bound.after", 1'b1, 1'b1, 32'hA1, 3'd3);
        for (int i = 1; i < 4; i++) begin
            deq__ENA = 1'b1;
            chk($sformatf("bound.drain%0d", i), first, 32'hA0 + 32'(i));
            tick();
        end
        deq__ENA = 1'b0;
        chk_state("bound.empty", 1'b1, 1'b0, 32'd0, 3'd0);

        // Asynchronous reset mid-cycle with entries queued
        say__ENA = 1'b1; say_v = 32'h77;
        tick();
        say_v = 32'h78;
        tick();
        say__ENA = 1'b0;
        chk_state("midrst.pre", 1'b1, 1'b1, 32'h77, 3'd2);
        #2 nRST = 1'b0;
        #1 chk_state("midrst", 1'b1, 1'b0, 32'd0, 3'd0);
`ifdef ECHO_REQ_STATS_EN
        chk("midrst.req_total", req_total, 32'd0);
`endif
        #2 nRST = 1'b1;
        tick();
        say__ENA = 1'b1; say_v = 32'h123;
        tick();
        say__ENA = 1'b0;
        chk_state("postrst", 1'b1, 1'b1, 32'h123, 3'd1);
        deq__ENA = 1'b1;
        tick();
        deq__ENA = 1'b0;

`ifdef ECHO_REQ_STATS_EN
        // Counter wrap from a preloaded value
        dut.req_total_q = 32'hFFFF_FFFE;
        #1;
        say__ENA = 1'b1; say_v = 32'h1;
        tick();
        chk("stats.ffff", req_total, 32'hFFFF_FFFF);
        say_v = 32'h2;
        tick();
        say__ENA = 1'b0;
        chk("stats.wrap", req_total, 32'd0);
        chk("stats.count", 32'(count), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
